ft245_stream_bridge: RTL
========================

# ft245_stream_bridge

Parametrised FT232H asynchronous 245-FIFO bridge between the UM232H-B breakout and on-chip logic. It assembles received USB bytes into WORD_BYTES-wide words and streams a block of NR_WORDS RAM words to the PC, one byte at a time, least-significant byte first. All FT232H strobe widths are set by parameters, and a RAM read-latency stage lets the block sit directly on a synchronous M9K port. It sits between the GPIO pin mapping at top level and the sample RAM and command decoder.

## Interface
- WORD_BYTES, 1: bytes per word, 1..4, for both RX and TX.
- ADDR_W, 8: RAM address width.
- NR_WORDS, 256: words per TX block, 1..2^ADDR_W.
- RAM_LAT, 1: cycles from a tx_addr change to a valid tx_word, 1..3.
- RD_LOW_CYC, 3: ft_rd_n low width in cycles, at least 2.
- SETUP_CYC, 1: cycles data is driven before ft_wr_n falls, at least 1.
- WR_LOW_CYC, 2: ft_wr_n low width in cycles, at least 1.
- RECOV_CYC, 3: strobe-high recovery in cycles, at least 3 so it covers synchronizer latency.
- CLOCK_50 in 1: the single clock; all logic is on the rising edge.
- reset in 1: asynchronous, active-high; clears all state.
- ft_rxf_n in 1: FT232H RXF#, asynchronous; low means RX data is available.
- ft_txe_n in 1: FT232H TXE#, asynchronous; low means TX space is available.
- ft_data_in in 8: data bus input.
- ft_data_out out 8: data bus output value.
- ft_data_oe out 1: tristate enable for the data bus, used at top level.
- ft_rd_n out 1: RD#.
- ft_wr_n out 1: WR#.
- tx_start in 1: starts a block; sampled only in IDLE.
- tx_addr out ADDR_W: RAM read address.
- tx_word in 8*WORD_BYTES: RAM read data.
- tx_busy out 1: high from the cycle after tx_start is accepted until tx_done.
- tx_done out 1: one-cycle pulse when the block completes.
- rx_word out 8*WORD_BYTES: assembled RX word; byte 0 is the first byte received.
- rx_valid out 1: one-cycle pulse when rx_word updates.
- state_dbg out 4: current state encoding, for the LEDs.

## Operation
- Synchronizers: ft_rxf_n and ft_txe_n each pass through 2 flops, and both reset to 1. All FSM decisions use the synchronized copies.
- The FSM has these states: IDLE, RD_LOW, RD_RECOV, TX_FETCH, TX_WAIT, TX_SETUP, TX_LOW, TX_RECOV.
- IDLE:
  - If tx_start=1, go to TX_FETCH. tx_start has priority over RX.
  - Else if rxf=0, go to RD_LOW.
- RD_LOW:
  - ft_rd_n=0 for RD_LOW_CYC cycles.
  - ft_data_in is registered on the last low cycle into byte slot rx_cnt.
  - rx_cnt then increments.
  - When rx_cnt wraps at WORD_BYTES-1→0, rx_word is updated with the completed word and rx_valid pulses.
  - Then go to RD_RECOV.
- RD_RECOV: ft_rd_n=1 for RECOV_CYC cycles, then go to IDLE.
- TX_FETCH:
  - tx_addr holds the current word address.
  - Wait RAM_LAT cycles, latch tx_word into a shift register, set byte_idx=0, and go to TX_WAIT.
- TX_WAIT: go to TX_SETUP when txe=0; otherwise stay, with no timeout.
- TX_SETUP:
  - ft_data_out = shift[7:0], ft_data_oe=1, ft_wr_n=1.
  - Hold for SETUP_CYC cycles.
- TX_LOW: ft_wr_n=0 and ft_data_oe=1 for WR_LOW_CYC cycles.
- TX_RECOV:
  - ft_wr_n=1.
  - ft_data_oe stays 1 in the first recovery cycle as data hold, then goes to 0.
  - Lasts RECOV_CYC cycles.
  - At the end, shift right by 8 and increment byte_idx.
- Routing after TX_RECOV:
  - If byte_idx < WORD_BYTES, go to TX_WAIT.
  - Else if word_cnt+1 < NR_WORDS, increment tx_addr and word_cnt, then go to TX_FETCH.
  - Else pulse tx_done, set tx_addr=0 and word_cnt=0, and go to IDLE.
- rx_cnt persists across TX blocks, so a partial RX word resumes after a TX block.
- tx_start while busy is ignored.
- ft_rd_n and ft_wr_n are never low in the same cycle.
- ft_data_oe=1 only in TX states.
- Widths:
  - word_cnt is ADDR_W+1 bits, so NR_WORDS=2^ADDR_W does not overflow.
  - byte_idx and rx_cnt are max(1, clog2(WORD_BYTES)) bits.
  - tx_addr wraps naturally only when NR_WORDS=2^ADDR_W, and is cleared at block end.

## Timing
- Reset values:
  - ft_rd_n=1, ft_wr_n=1, ft_data_oe=0, ft_data_out=0.
  - tx_addr=0, tx_busy=0, tx_done=0.
  - rx_word=0, rx_valid=0, state=IDLE.
  - rx_cnt=0, byte_idx=0, word_cnt=0.
- Reset mid-transfer: strobes are released asynchronously, the bus is tri-stated immediately, and any partial word is discarded.
- RX byte period = 1 (IDLE) + RD_LOW_CYC + RECOV_CYC cycles, minimum. With defaults this is 7 cycles.
- TX byte period = SETUP_CYC + WR_LOW_CYC + RECOV_CYC + 1 (TX_WAIT) cycles, when TXE is low throughout.
- TX_FETCH adds RAM_LAT+1 cycles per word.
- RXF/TXE latency to a decision is 2 cycles, from the synchronizer.
- tx_done and tx_busy=0 occur in the same cycle.

## Test plan
- WORD_BYTES=2, PC sends 0x34 then 0x12 → one rx_valid pulse with rx_word=0x1234; ft_rd_n low for exactly 3 cycles per byte.
- NR_WORDS=4, WORD_BYTES=1, RAM[i]=0xA0+i, TXE tied low → bus shows 0xA0,0xA1,0xA2,0xA3 at each ft_wr_n fall; tx_done occurs once; tx_addr returns to 0.
- WORD_BYTES=4, tx_word=0xDDCCBBAA, NR_WORDS=1 → bytes AA,BB,CC,DD in order; ft_data_oe stays 1 from the first SETUP cycle through the first cycle after each WR# rise.
- TXE held high for 50 cycles mid-block → FSM stays in TX_WAIT, no WR# strobe, data resumes with the correct byte; tx_start pulses while busy are ignored.
- tx_start and RXF low in the same cycle → TX block runs first; RX byte is read after tx_done; rx_word is correct.
- reset asserted during TX_LOW → ft_wr_n=1 and ft_data_oe=0 within the same cycle, with no further strobes; the next tx_start restarts at address 0.

Source files
------------

// File: rtl/ft245_stream_bridge_if.sv
// Pin bundle for the FT232H asynchronous 245-FIFO bus.
// The bridge is the master (drives strobes and data); the FT232H side is the slave.
interface ft245_stream_bridge_if;
   logic       ft_rxf_n;
   logic       ft_txe_n;
   logic [7:0] ft_data_in;
   logic [7:0] ft_data_out;
   logic       ft_data_oe;
   logic       ft_rd_n;
   logic       ft_wr_n;

   modport master (
      input  ft_rxf_n,
      input  ft_txe_n,
      input  ft_data_in,
      output ft_data_out,
      output ft_data_oe,
      output ft_rd_n,
      output ft_wr_n
   );

   modport slave (
      output ft_rxf_n,
      output ft_txe_n,
      output ft_data_in,
      input  ft_data_out,
      input  ft_data_oe,
      input  ft_rd_n,
      input  ft_wr_n
   );
endinterface

// File: rtl/ft245_stream_bridge.sv
// FT232H 245-FIFO bridge: assembles RX bytes into words and streams a RAM block to the PC,
// least-significant byte first, with parameterised strobe widths and RAM read latency.
module ft245_stream_bridge #(
   parameter int WORD_BYTES = 1,
   parameter int ADDR_W     = 8,
   parameter int NR_WORDS   = 256,
   parameter int RAM_LAT    = 1,
   parameter int RD_LOW_CYC = 3,
   parameter int SETUP_CYC  = 1,
   parameter int WR_LOW_CYC = 2,
   parameter int RECOV_CYC  = 3
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   ft245_stream_bridge_if.master   ft,
   input  logic                    tx_start,
   output logic [ADDR_W-1:0]       tx_addr,
   input  logic [8*WORD_BYTES-1:0] tx_word,
   output logic                    tx_busy,
   output logic                    tx_done,
   output logic [8*WORD_BYTES-1:0] rx_word,
   output logic                    rx_valid,
   output logic [3:0]              state_dbg
);

   localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int CNT_W  = 16;
   localparam int WORD_W = 8 * WORD_BYTES;

   localparam logic [CNT_W-1:0]  RD_LOW_LAST = CNT_W'(RD_LOW_CYC - 1);
   localparam logic [CNT_W-1:0]  FETCH_LAST  = CNT_W'(RAM_LAT);
   localparam logic [CNT_W-1:0]  SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0]  WR_LOW_LAST = CNT_W'(WR_LOW_CYC - 1);
   localparam logic [CNT_W-1:0]  RECOV_LAST  = CNT_W'(RECOV_CYC - 1);
   localparam logic [IDX_W-1:0]  RX_LAST     = IDX_W'(WORD_BYTES - 1);
   localparam logic [ADDR_W:0]   NR_WORDS_W  = (ADDR_W + 1)'(NR_WORDS);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      RD_LOW   = 4'd1,
      RD_RECOV = 4'd2,
      TX_FETCH = 4'd3,
      TX_WAIT  = 4'd4,
      TX_SETUP = 4'd5,
      TX_LOW   = 4'd6,
      TX_RECOV = 4'd7
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               rxf_meta_q, rxf_meta_d, rxf_sync_q, rxf_sync_d;
   logic               txe_meta_q, txe_meta_d, txe_sync_q, txe_sync_d;
   logic               rd_n_q, rd_n_d;
   logic               wr_n_q, wr_n_d;
   logic               oe_q, oe_d;
   logic [7:0]         data_out_q, data_out_d;
   logic [ADDR_W-1:0]  tx_addr_q, tx_addr_d;
   logic [ADDR_W:0]    word_cnt_q, word_cnt_d;
   logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
   logic [WORD_W-1:0]  shift_q, shift_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [IDX_W-1:0]   rx_cnt_q, rx_cnt_d;
   logic [WORD_W-1:0]  rx_buf_q, rx_buf_d;
   logic [WORD_W-1:0]  rx_word_q, rx_word_d;
   logic               rx_valid_q, rx_valid_d;

   // Next-state logic; every pin-facing output is derived from the next state so it is registered.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tx_addr_d  = tx_addr_q;
      word_cnt_d = word_cnt_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rx_cnt_d   = rx_cnt_q;
      rx_buf_d   = rx_buf_q;
      rx_word_d  = rx_word_q;
      rx_valid_d = 1'b0;
      data_out_d = data_out_q;
      rxf_meta_d = ft.ft_rxf_n;
      rxf_sync_d = rxf_meta_q;
      txe_meta_d = ft.ft_txe_n;
      txe_sync_d = txe_meta_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (tx_start) begin
               state_d = TX_FETCH;
               busy_d  = 1'b1;
            end else if (!rxf_sync_q) begin
               state_d = RD_LOW;
            end
         end
         RD_LOW: begin
            if (cnt_q == RD_LOW_LAST) begin
               cnt_d   = '0;
               state_d = RD_RECOV;
               for (int b = 0; b < WORD_BYTES; b++) begin
                  if (rx_cnt_q == IDX_W'(b)) begin
                     rx_buf_d[b*8 +: 8] = ft.ft_data_in;
                  end
               end
               if (rx_cnt_q == RX_LAST) begin
                  rx_cnt_d   = '0;
                  rx_word_d  = rx_buf_d;
                  rx_valid_d = 1'b1;
               end else begin
                  rx_cnt_d = rx_cnt_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RD_RECOV: begin
            if (cnt_q == RECOV_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         TX_FETCH: begin
            if (cnt_q == FETCH_LAST) begin
               cnt_d      = '0;
               shift_d    = tx_word;
               byte_idx_d = '0;
               state_d    = TX_WAIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         TX_WAIT: begin
            cnt_d = '0;
            if (!txe_sync_q) begin
               state_d = TX_SETUP;
            end
         end
         TX_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               cnt_d   = '0;
               state_d = TX_LOW;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         TX_LOW: begin
            if (cnt_q == WR_LOW_LAST) begin
               cnt_d   = '0;
               state_d = TX_RECOV;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         TX_RECOV: begin
            if (cnt_q == RECOV_LAST) begin
               cnt_d      = '0;
               shift_d    = shift_q >> 8;
               byte_idx_d = byte_idx_q + 1'b1;
               if (int'(byte_idx_q) < WORD_BYTES - 1) begin
                  state_d = TX_WAIT;
               end else if ((word_cnt_q + 1'b1) < NR_WORDS_W) begin
                  word_cnt_d = word_cnt_q + 1'b1;
                  tx_addr_d  = tx_addr_q + 1'b1;
                  state_d    = TX_FETCH;
               end else begin
                  done_d     = 1'b1;
                  busy_d     = 1'b0;
                  tx_addr_d  = '0;
                  word_cnt_d = '0;
                  state_d    = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Data stays driven through the first recovery cycle as hold time after WR# rises.
      rd_n_d = (state_d != RD_LOW);
      wr_n_d = (state_d != TX_LOW);
      oe_d   = (state_d == TX_SETUP) || (state_d == TX_LOW) ||
               ((state_d == TX_RECOV) && (cnt_d == '0));
      if (state_d == TX_SETUP) begin
         data_out_d = shift_q[7:0];
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rxf_meta_q <= 1'b1;
         rxf_sync_q <= 1'b1;
         txe_meta_q <= 1'b1;
         txe_sync_q <= 1'b1;
         rd_n_q     <= 1'b1;
         wr_n_q     <= 1'b1;
         oe_q       <= 1'b0;
         data_out_q <= '0;
         tx_addr_q  <= '0;
         word_cnt_q <= '0;
         byte_idx_q <= '0;
         shift_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rx_cnt_q   <= '0;
         rx_buf_q   <= '0;
         rx_word_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rxf_meta_q <= rxf_meta_d;
         rxf_sync_q <= rxf_sync_d;
         txe_meta_q <= txe_meta_d;
         txe_sync_q <= txe_sync_d;
         rd_n_q     <= rd_n_d;
         wr_n_q     <= wr_n_d;
         oe_q       <= oe_d;
         data_out_q <= data_out_d;
         tx_addr_q  <= tx_addr_d;
         word_cnt_q <= word_cnt_d;
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_buf_q   <= rx_buf_d;
         rx_word_q  <= rx_word_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign ft.ft_rd_n      = rd_n_q;
   assign ft.ft_wr_n      = wr_n_q;
   assign ft.ft_data_oe   = oe_q;
   assign ft.ft_data_out  = data_out_q;
   assign tx_addr         = tx_addr_q;
   assign tx_busy         = busy_q;
   assign tx_done         = done_q;
   assign rx_word         = rx_word_q;
   assign rx_valid        = rx_valid_q;
   assign state_dbg       = state_q;

endmodule
